// File: rtl/lock_pkg.sv
// Shared definitions for the lock controller datapath: key codes, compare targets
// and the compare-sequencer state encoding.
package lock_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] KEY_CANCEL = 4'd7;
  localparam logic [DIGIT_W-1:0] KEY_PROG   = 4'd8;
  localparam logic [DIGIT_W-1:0] KEY_LOCK   = 4'd9;

  typedef enum logic [1:0] {
    CMP_PC  = 2'b00,
    CMP_UC  = 2'b01,
    CMP_SH  = 2'b10,
    CMP_RSV = 2'b11
  } cmp_sel_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LEN  = 2'd1,
    S_SCAN = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Anything at or above KEY_CANCEL is a command or unused code, never a digit.
  function automatic logic is_digit_key(input logic [DIGIT_W-1:0] key);
    return (key < KEY_CANCEL) && (key != KEY_PROG) && (key != KEY_LOCK);
  endfunction

endpackage

// File: rtl/digit_buffer.sv
// Digit register array with a saturating length counter and overflow flag.
// Element 0 holds the first digit entered.
module digit_buffer
  import lock_pkg::*;
#(
  parameter int MAX_DIGITS = 8,
  parameter int LEN_W = $clog2(MAX_DIGITS + 1),
  parameter logic [MAX_DIGITS*DIGIT_W-1:0] RESET_DIGITS = '0,
  parameter logic [LEN_W-1:0] RESET_LEN = '0
) (
  input  logic                          hwclk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          append,
  input  logic [DIGIT_W-1:0]            append_digit,
  input  logic                          load,
  input  logic [MAX_DIGITS*DIGIT_W-1:0] load_digits,
  input  logic [LEN_W-1:0]              load_len,
  input  logic                          load_ovf,
  output logic [MAX_DIGITS*DIGIT_W-1:0] digits,
  output logic [LEN_W-1:0]              len,
  output logic                          ovf
);

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      digits <= RESET_DIGITS;
      len    <= RESET_LEN;
      ovf    <= 1'b0;
    end else if (load) begin
      digits <= load_digits;
      len    <= load_len;
      ovf    <= load_ovf;
    end else if (clr) begin
      len <= '0;
      ovf <= 1'b0;
    end else if (append) begin
      if (len == LEN_W'(MAX_DIGITS)) begin
        ovf <= 1'b1;
      end else begin
        for (int i = 0; i < MAX_DIGITS; i++) begin
          if (LEN_W'(i) == len) digits[i*DIGIT_W +: DIGIT_W] <= append_digit;
        end
        len <= len + 1'b1;
      end
    end
  end

endmodule

// File: rtl/code_match_sequencer.sv
// Entry/shadow/user-code buffers and the digit-serial compare engine driven by the
// lock controller. Packed code constants read left to right in key-entry order.
module code_match_sequencer
  import lock_pkg::*;
#(
  parameter int MAX_DIGITS = 8,
  parameter int MIN_UC_LEN = 4,
  parameter int PC_LEN = 6,
  parameter logic [PC_LEN*DIGIT_W-1:0] PASSCODE = 24'h012345,
  parameter logic [MAX_DIGITS*DIGIT_W-1:0] RESET_UC = 32'h0000_3210,
  parameter int RESET_UC_LEN = 4
) (
  input  logic               hwclk,
  input  logic               rst_n,
  input  logic               digit_valid,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               read_input,
  input  logic               clr,
  input  logic               latch_shadow,
  input  logic               check,
  input  logic [1:0]         compare_sel,
  input  logic               store,
  output logic               validLength,
  output logic               validLengthPC,
  output logic               busy,
  output logic               data_ready,
  output logic               correct_input
);

  localparam int LEN_W = $clog2(MAX_DIGITS + 1);
  localparam int BUF_W = MAX_DIGITS * DIGIT_W;

  // The most recently keyed digit of a literal sits in its LSBs; buffers store first key at element 0.
  function automatic logic [BUF_W-1:0] typed_order(input logic [BUF_W-1:0] code, input int n);
    logic [BUF_W-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i*DIGIT_W +: DIGIT_W] = code[(n-1-i)*DIGIT_W +: DIGIT_W];
    return r;
  endfunction

  localparam logic [BUF_W-1:0] PC_FLAT = typed_order(BUF_W'(PASSCODE), PC_LEN);
  localparam logic [BUF_W-1:0] UC_FLAT = typed_order(RESET_UC, RESET_UC_LEN);

  logic [BUF_W-1:0] ent_digits, sh_digits, uc_digits, tgt_digits;
  logic [LEN_W-1:0] ent_len, sh_len, uc_len, tgt_len;
  logic             ent_ovf, sh_ovf, uc_ovf, tgt_ovf;
  logic [DIGIT_W-1:0] ent_digit, tgt_digit;

  state_e           state, state_n;
  logic [LEN_W-1:0] idx, idx_n;
  cmp_sel_e         sel_q, sel_n;
  logic             res_q, res_n, ready_n, correct_n;
  logic             abort, capture, store_ok, len_reject;

  assign busy     = (state == S_LEN) || (state == S_SCAN);
  assign abort    = clr | latch_shadow;
  assign capture  = digit_valid & read_input & is_digit_key(digit) & ~busy & ~abort;
  assign store_ok = store & ~busy & (sh_len >= LEN_W'(MIN_UC_LEN)) & ~sh_ovf;

  assign validLength   = ~ent_ovf & (ent_len >= LEN_W'(MIN_UC_LEN));
  assign validLengthPC = ~ent_ovf & (ent_len == LEN_W'(PC_LEN));

  digit_buffer #(.MAX_DIGITS(MAX_DIGITS)) u_entry (
    .hwclk(hwclk), .rst_n(rst_n),
    .clr(abort), .append(capture), .append_digit(digit),
    .load(1'b0), .load_digits('0), .load_len('0), .load_ovf(1'b0),
    .digits(ent_digits), .len(ent_len), .ovf(ent_ovf)
  );

  digit_buffer #(.MAX_DIGITS(MAX_DIGITS)) u_shadow (
    .hwclk(hwclk), .rst_n(rst_n),
    .clr(1'b0), .append(1'b0), .append_digit('0),
    .load(latch_shadow), .load_digits(ent_digits), .load_len(ent_len), .load_ovf(ent_ovf),
    .digits(sh_digits), .len(sh_len), .ovf(sh_ovf)
  );

  digit_buffer #(
    .MAX_DIGITS(MAX_DIGITS),
    .RESET_DIGITS(UC_FLAT),
    .RESET_LEN(LEN_W'(RESET_UC_LEN))
  ) u_uc (
    .hwclk(hwclk), .rst_n(rst_n),
    .clr(1'b0), .append(1'b0), .append_digit('0),
    .load(store_ok), .load_digits(sh_digits), .load_len(sh_len), .load_ovf(sh_ovf),
    .digits(uc_digits), .len(uc_len), .ovf(uc_ovf)
  );

  always_comb begin
    tgt_digits = '0;
    tgt_len    = '0;
    tgt_ovf    = 1'b0;
    case (sel_q)
      CMP_PC: begin tgt_digits = PC_FLAT;   tgt_len = LEN_W'(PC_LEN); end
      CMP_UC: begin tgt_digits = uc_digits; tgt_len = uc_len; tgt_ovf = uc_ovf; end
      CMP_SH: begin tgt_digits = sh_digits; tgt_len = sh_len; end
      default: ;
    endcase
  end

  always_comb begin
    ent_digit = '0;
    tgt_digit = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (LEN_W'(i) == idx) begin
        ent_digit = ent_digits[i*DIGIT_W +: DIGIT_W];
        tgt_digit = tgt_digits[i*DIGIT_W +: DIGIT_W];
      end
    end
  end

  assign len_reject = (sel_q == CMP_RSV) | ent_ovf | tgt_ovf | (ent_len == '0) | (ent_len != tgt_len);

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    sel_n     = sel_q;
    res_n     = res_q;
    ready_n   = data_ready;
    correct_n = correct_input;
    if (abort) begin
      state_n   = S_IDLE;
      ready_n   = 1'b0;
      correct_n = 1'b0;
    end else if (check) begin
      state_n   = S_LEN;
      sel_n     = cmp_sel_e'(compare_sel);
      ready_n   = 1'b0;
      correct_n = 1'b0;
    end else begin
      case (state)
        S_LEN: begin
          if (len_reject) begin
            state_n = S_DONE;
            res_n   = 1'b0;
          end else begin
            state_n = S_SCAN;
            idx_n   = '0;
          end
        end
        S_SCAN: begin
          if (ent_digit != tgt_digit) begin
            state_n = S_DONE;
            res_n   = 1'b0;
          end else if (idx == ent_len - 1'b1) begin
            state_n = S_DONE;
            res_n   = 1'b1;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
        S_DONE: begin
          state_n   = S_IDLE;
          ready_n   = 1'b1;
          correct_n = res_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      idx           <= '0;
      sel_q         <= CMP_PC;
      res_q         <= 1'b0;
      data_ready    <= 1'b0;
      correct_input <= 1'b0;
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      sel_q         <= sel_n;
      res_q         <= res_n;
      data_ready    <= ready_n;
      correct_input <= correct_n;
    end
  end

endmodule

// File: tb/tb_code_match_sequencer.sv
// Directed and randomized checks of code_match_sequencer against a queue-based model
// of entry, shadow and user-code contents and the compare latency rules.
module tb_code_match_sequencer;

  localparam int MAX_DIGITS = 8;
  localparam int MIN_UC_LEN = 4;
  localparam int PC_LEN = 6;
  localparam logic [23:0] PASSCODE = 24'h012345;
  localparam logic [31:0] RESET_UC = 32'h0000_3210;
  localparam int RESET_UC_LEN = 4;

  logic hwclk = 1'b0;
  logic rst_n = 1'b0;
  logic digit_valid = 1'b0, read_input = 1'b1, clr = 1'b0, latch_shadow = 1'b0;
  logic check = 1'b0, store = 1'b0;
  logic [3:0] digit = 4'd0;
  logic [1:0] compare_sel = 2'd0;
  logic validLength, validLengthPC, busy, data_ready, correct_input;

  int total = 0;
  int bad = 0;

  int entry[$], sh[$], uc[$], pc[$];
  bit eovf, sh_ovf, m_busy, m_dr, m_ci;

  always #5 hwclk = ~hwclk;

  code_match_sequencer #(
    .MAX_DIGITS(MAX_DIGITS), .MIN_UC_LEN(MIN_UC_LEN), .PC_LEN(PC_LEN),
    .PASSCODE(PASSCODE), .RESET_UC(RESET_UC), .RESET_UC_LEN(RESET_UC_LEN)
  ) dut (
    .hwclk(hwclk), .rst_n(rst_n), .digit_valid(digit_valid), .digit(digit),
    .read_input(read_input), .clr(clr), .latch_shadow(latch_shadow), .check(check),
    .compare_sel(compare_sel), .store(store), .validLength(validLength),
    .validLengthPC(validLengthPC), .busy(busy), .data_ready(data_ready),
    .correct_input(correct_input)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    entry.delete(); sh.delete(); uc.delete();
    eovf = 0; sh_ovf = 0; m_busy = 0; m_dr = 0; m_ci = 0;
    for (int i = RESET_UC_LEN - 1; i >= 0; i--) uc.push_back(int'((RESET_UC >> (4 * i)) & 32'hF));
  endtask

  // Apply the currently driven inputs for one clock edge and advance the model.
  task automatic cyc();
    bit cap;
    cap = digit_valid && read_input && (digit <= 4'd6) && !m_busy;
    if (store && !m_busy && sh.size() >= MIN_UC_LEN && !sh_ovf) uc = sh;
    if (latch_shadow) begin
      sh = entry; sh_ovf = eovf; entry.delete(); eovf = 0;
    end else if (clr) begin
      entry.delete(); eovf = 0;
    end else if (cap) begin
      if (entry.size() == MAX_DIGITS) eovf = 1;
      else entry.push_back(int'(digit));
    end
    if (clr || latch_shadow || check) begin m_dr = 0; m_ci = 0; end
    @(posedge hwclk);
    #1;
    digit_valid = 0; clr = 0; latch_shadow = 0; check = 0; store = 0;
  endtask

  task automatic key(input int d);
    digit_valid = 1;
    digit = 4'(d);
    cyc();
  endtask

  task automatic chk_state();
    chk("validLength", validLength, (entry.size() >= MIN_UC_LEN) && !eovf);
    chk("validLengthPC", validLengthPC, (entry.size() == PC_LEN) && !eovf);
    chk("data_ready", data_ready, m_dr);
    if (m_dr) chk("correct_input", correct_input, m_ci);
  endtask

  task automatic do_check(input int sel, input bit junk);
    int lat;
    bit res;
    int tq[$];
    compare_sel = 2'(sel);
    check = 1;
    cyc();
    case (sel)
      0: tq = pc;
      1: tq = uc;
      2: tq = sh;
      default: tq.delete();
    endcase
    if (sel == 3 || eovf || entry.size() == 0 || entry.size() != tq.size()) begin
      lat = 2; res = 0;
    end else begin
      lat = entry.size() + 2; res = 1;
      for (int k = 0; k < entry.size(); k++) begin
        if (entry[k] != tq[k]) begin lat = k + 3; res = 0; break; end
      end
    end
    chk("busy_start", busy, 1'b1);
    chk("ready_start", data_ready, 1'b0);
    for (int i = 1; i <= lat; i++) begin
      if (junk && i < lat) begin
        if ($urandom_range(0, 1) == 1) begin
          digit_valid = 1; digit = 4'($urandom_range(0, 6)); read_input = 1;
        end
        if ($urandom_range(0, 7) == 0) store = 1;
      end
      m_busy = (i < lat);
      cyc();
      chk("busy_scan", busy, i < lat - 1);
      chk("ready_timing", data_ready, i >= lat);
    end
    m_busy = 0; m_dr = 1; m_ci = res;
    chk("correct_result", correct_input, res);
  endtask

  initial begin
    for (int i = PC_LEN - 1; i >= 0; i--) pc.push_back(int'((PASSCODE >> (4 * i)) & 24'hF));
    model_reset();

    #3;
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", data_ready, 1'b0);
    chk("rst_correct", correct_input, 1'b0);
    chk("rst_vlen", validLength, 1'b0);
    chk("rst_vlenpc", validLengthPC, 1'b0);
    @(negedge hwclk) rst_n = 1;
    @(posedge hwclk); #1;

    // passcode match, then mismatch on the last digit
    for (int d = 0; d < 6; d++) key(d);
    chk_state();
    do_check(0, 0);
    chk_state();
    clr = 1; cyc(); chk_state();
    foreach (pc[k]) key(k == 5 ? 6 : pc[k]);
    do_check(0, 0);
    clr = 1; cyc();

    // overflow
    for (int d = 0; d < 8; d++) key(d % 7);
    chk_state();
    key(2);
    chk_state();
    do_check(1, 0);
    clr = 1; cyc();

    // shadow compare, store, user-code compare
    key(5); key(5); key(6); key(6);
    latch_shadow = 1; cyc(); chk_state();
    key(5); key(5); key(6); key(6);
    do_check(2, 0);
    store = 1; cyc(); chk_state();
    do_check(1, 0);
    clr = 1; cyc();
    key(3); key(2); key(1); key(0);
    do_check(1, 0);
    clr = 1; cyc();

    // clr while busy aborts; keys during busy are dropped
    for (int d = 0; d < 6; d++) key(d);
    compare_sel = 2'd0; check = 1; cyc();
    for (int i = 0; i < 2; i++) begin
      digit_valid = 1; digit = 4'd3; m_busy = 1;
      cyc();
      chk("busy_hold", busy, 1'b1);
      chk_state();
    end
    clr = 1; cyc(); m_busy = 0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_correct", correct_input, 1'b0);
    chk_state();

    // reset mid-scan, then a rejected short store
    for (int d = 0; d < 6; d++) key(d);
    compare_sel = 2'd0; check = 1; cyc();
    m_busy = 1;
    for (int i = 0; i < 3; i++) cyc();
    chk("scan_busy", busy, 1'b1);
    rst_n = 0;
    #2;
    model_reset();
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", data_ready, 1'b0);
    chk("midrst_correct", correct_input, 1'b0);
    chk("midrst_vlen", validLength, 1'b0);
    chk("midrst_vlenpc", validLengthPC, 1'b0);
    #2 rst_n = 1;
    cyc(); chk_state();
    key(1); key(2); key(3);
    latch_shadow = 1; cyc();
    store = 1; cyc(); chk_state();
    key(3); key(2); key(1); key(0);
    do_check(1, 0);
    clr = 1; cyc();

    for (int it = 0; it < 40; it++) begin
      int sel;
      int n;
      int tq[$];
      sel = $urandom_range(0, 3);
      clr = 1; cyc();
      case (sel)
        0: tq = pc;
        1: tq = uc;
        2: tq = sh;
        default: tq.delete();
      endcase
      if ($urandom_range(0, 1) == 1) begin
        foreach (tq[k]) key(tq[k]);
        if ($urandom_range(0, 2) == 0) key($urandom_range(0, 6));
      end else begin
        n = $urandom_range(0, 10);
        for (int k = 0; k < n; k++) begin
          read_input = ($urandom_range(0, 7) != 0);
          key($urandom_range(0, 9));
        end
        read_input = 1;
      end
      if ($urandom_range(0, 3) == 0) begin
        latch_shadow = 1; cyc();
        n = $urandom_range(3, 8);
        for (int k = 0; k < n; k++) key($urandom_range(0, 6));
      end
      chk_state();
      if ($urandom_range(0, 2) == 0) store = 1;
      do_check(sel, 1);
      chk_state();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
